// File: rtl/seq_lock_n.sv
// Registered partial-activity detector: z is high while some but not all of x are high,
// with a lockout after all-high that clears on all-low. Optional timeout: SEQ_LOCK_TIMEOUT_EN.
module seq_lock_n #(
  parameter int N       = 2,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     x,
  input  logic             cnt_clr,
  output logic             z,
  output logic             locked,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] act_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_q;
  logic   is_zero;
  logic   is_all;
  logic   is_part;

  assign is_zero = (x == '0);
  assign is_all  = (x == '1);
  assign is_part = !is_zero && !is_all;
  assign state   = state_q;

`ifdef SEQ_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] timer_q;
`endif

  // z and locked are registered copies of the next state, so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      z       <= 1'b0;
      locked  <= 1'b0;
      act_cnt <= '0;
`ifdef SEQ_LOCK_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      // NOTE: every register in this block uses <= so all of them see the same pre-edge state.
      case (state_q)
        IDLE, ACTIVE: begin
          if (is_zero) begin
            state_q <= IDLE;
            z       <= 1'b0;
            locked  <= 1'b0;
          end else if (is_all) begin
            state_q <= LOCKED;
            z       <= 1'b0;
            locked  <= 1'b1;
          end else begin
            state_q <= ACTIVE;
            z       <= 1'b1;
            locked  <= 1'b0;
`ifdef SEQ_LOCK_TIMEOUT_EN
            if (state_q == IDLE) begin
              timer_q <= '0;
            end else if (timer_q == TIMER_LAST) begin
              state_q <= LOCKED;
              z       <= 1'b0;
              locked  <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
`endif
          end
        end
        LOCKED: begin
          if (is_zero) begin
            state_q <= IDLE;
            z       <= 1'b0;
            locked  <= 1'b0;
          end else begin
            state_q <= LOCKED;
            z       <= 1'b0;
            locked  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          z       <= 1'b0;
          locked  <= 1'b0;
        end
      endcase

      // Only fresh IDLE->ACTIVE entries count; clear has priority over the increment.
      if (cnt_clr) begin
        act_cnt <= '0;
      end else if (state_q == IDLE && is_part && act_cnt != CNT_MAX) begin
        act_cnt <= act_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_lock_n.sv
// Scoreboard bench for seq_lock_n: stimulus pushes model predictions, a monitor pops and
// compares after every rising edge. Follows SEQ_LOCK_TIMEOUT_EN when defined.
module tb_seq_lock_n;

  localparam int N       = 2;
  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     x;
  logic             cnt_clr;
  logic             z;
  logic             locked;
  logic [1:0]       state;
  logic [CNT_W-1:0] act_cnt;

  seq_lock_n #(.N(N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .cnt_clr (cnt_clr),
    .z       (z),
    .locked  (locked),
    .state   (state),
    .act_cnt (act_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int z;
    int locked;
    int state;
    int act_cnt;
    int step_no;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // Reference model: "mode" is a plain word, the activity run is a count of cycles z has been high.
  string m_mode = "idle";
  int    m_entries = 0;
  int    m_run = 0;

  task automatic check(input string name, input int step, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at step %0d: got %0d expected %0d", name, step, actual, expected);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] xv, input logic c);
    exp_t e;
    bit part;
    @(negedge clk);
    rst = r;
    x = xv;
    cnt_clr = c;
    step_no++;
    part = (xv != 0) && (xv != {N{1'b1}});
    if (r) begin
      m_mode = "idle";
      m_entries = 0;
      m_run = 0;
    end else begin
      if (xv == 0) begin
        m_mode = "idle";
      end else if (!part) begin
        m_mode = "locked";
      end else if (m_mode == "idle") begin
        m_mode = "active";
        m_run = 1;
        if (m_entries < CNT_SAT) m_entries++;
      end else if (m_mode == "active") begin
`ifdef SEQ_LOCK_TIMEOUT_EN
        if (m_run >= TIMEOUT) m_mode = "locked";
        else m_run++;
`else
        m_run++;
`endif
      end
      if (c) m_entries = 0;
    end
    e.z       = (m_mode == "active") ? 1 : 0;
    e.locked  = (m_mode == "locked") ? 1 : 0;
    e.state   = (m_mode == "active") ? 1 : (m_mode == "locked") ? 2 : 0;
    e.act_cnt = m_entries;
    e.step_no = step_no;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle, so one prediction is consumed per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("z",       e.step_no, int'(z),       e.z);
        check("locked",  e.step_no, int'(locked),  e.locked);
        check("state",   e.step_no, int'(state),   e.state);
        check("act_cnt", e.step_no, int'(act_cnt), e.act_cnt);
      end
    end
  end

  initial begin
    logic [N-1:0] seq2 [7];
    logic [N-1:0] xr;
    logic         rr;
    logic         cr;
    int           budget;
    rst = 1'b1;
    x = '0;
    cnt_clr = 1'b0;

    // Reset holds IDLE even with partial activity on x.
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b01, 1'b0);

    // Basic sequence through all three states; ends with two entries counted.
    seq2 = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
    foreach (seq2[i]) step(1'b0, seq2[i], 1'b0);

    // Counter saturation over five entries.
    step(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b00, 1'b0);
      step(1'b0, 2'b01, 1'b0);
    end

    // Clear beats a simultaneous entry; a plain entry then counts.
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b01, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b01, 1'b0);

    // Reset from LOCKED with all-high held, then re-lock without z, then all-low and re-entry.
    step(1'b0, 2'b11, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    step(1'b0, 2'b11, 1'b0);
    step(1'b0, 2'b11, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b01, 1'b0);

    // Sustained partial activity: timeout lock when enabled, persistent z otherwise.
    step(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 2'b01, 1'b0);

    // Randomised traffic, biased toward partial runs so the timeout path is exercised.
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 59) == 0);
      cr = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       xr = '0;
        1:       xr = '1;
        default: xr = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      endcase
      step(rr, xr, cr);
    end

    // Drain the scoreboard with a bounded wait.
    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_lock_n.md
Name: seq_lock_n

Overview:
- Clocked, parametrised successor to the team's two-input "partial-activity until all-high" sequential detector.
- Watches an N-bit input vector. Asserts z while some but not all inputs are high.
- Locks out z once all inputs have been high; the lock clears only when all inputs return low.
- Adds an activity-entry counter and an optional activity timeout. Sits beside control/status logic as a glitch-free, registered detector.

Parameters:
- N, 2, input vector width (N >= 2).
- CNT_W, 8, width of the activity-entry counter.
- TIMEOUT, 16, max consecutive ACTIVE cycles before forced lock; used only with the optional feature (TIMEOUT >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- x  input  N  monitored inputs, sampled every rising clk edge.
- cnt_clr  input  1  synchronous clear of act_cnt.
- z  output  1  registered detect output, equals (state==ACTIVE).
- locked  output  1  registered, equals (state==LOCKED).
- state  output  2  current state encoding: IDLE=2'b00, ACTIVE=2'b01, LOCKED=2'b10.
- act_cnt  output  CNT_W  saturating count of IDLE->ACTIVE entries.

Behaviour:
- Input class at each edge:
  - ZERO: x == 0.
  - ALL: x == all-ones.
  - PART: any other value.
- Reset: when rst=1 at an edge, the next values are state=IDLE, z=0, locked=0, act_cnt=0, and the timer is 0. Reset overrides all other inputs, including mid-ACTIVE or mid-LOCKED.
- Transitions, one per edge:
  - IDLE: ZERO->IDLE, PART->ACTIVE, ALL->LOCKED.
  - ACTIVE: ZERO->IDLE, PART->ACTIVE, ALL->LOCKED.
  - LOCKED: ZERO->IDLE, PART->LOCKED, ALL->LOCKED.
  - State 2'b11 is illegal and recovers to IDLE at the next edge. z=0 and locked=0 while in 2'b11.
- Latency: z and locked change one clk after the qualifying sample. There is no combinational path from x to any output.
- act_cnt:
  - Increments by 1 on an edge where state==IDLE and the class is PART.
  - ACTIVE->ACTIVE, LOCKED->*, and ACTIVE->IDLE transitions do not count.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 loads 0 and wins over a simultaneous increment. State and z are unaffected by cnt_clr.
- The state machine defines no X-handling; the bench drives known values only.

Optional Feature:
- Macro: SEQ_LOCK_TIMEOUT_EN.
- When defined:
  - Timer width is $clog2(TIMEOUT+1).
  - Timer loads 0 on every entry to ACTIVE.
  - Timer increments each edge where state==ACTIVE and the class is PART.
  - If state==ACTIVE, the class is PART and timer==TIMEOUT-1, the next state is LOCKED.
  - Result: z stays high for exactly TIMEOUT consecutive cycles under sustained PART.
  - ZERO and ALL transitions keep normal priority. The timer is held in IDLE and LOCKED.
- When undefined: no timer logic exists, and ACTIVE persists indefinitely under PART.

Test Plan:
1. rst=1 for 2 cycles with x=0 -> z=0, locked=0, state=00, act_cnt=0. Then with rst=1 and x=2'b01 -> state remains 00.
2. N=2: x=00,01,10,11,01,00,10, one cycle each -> z one cycle later is 0,1,1,0,0,0,1; locked is 0,0,0,1,1,0,0; final act_cnt=2.
3. CNT_W=2: alternate x=00/01 for five entries -> act_cnt after each entry is 1,2,3,3,3 (saturates, no wrap).
4. From IDLE, drive x=01 and cnt_clr=1 on the same edge -> act_cnt=0, z=1 next cycle. Repeat with cnt_clr=0 -> act_cnt=1.
5. N=4, LOCKED with x=1111: pulse rst one cycle -> state=IDLE, z=0. Release rst with x=1111 held -> locked=1 next cycle, z never asserts. Then x=0000 then 0001 -> z=1.
6. SEQ_LOCK_TIMEOUT_EN defined, TIMEOUT=4: hold x=0001 for 10 cycles from IDLE -> z high exactly 4 cycles, then locked=1; act_cnt=1. With the macro undefined -> z high all 10 cycles.
